// File: rtl/paddle_input_ctrl_pkg.sv
// Shared types and defaults for the paddle input front end.
// Optional feature macro used by the top: PADDLE_INPUT_STICKY_EN.
package paddle_input_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 650000;
  localparam int unsigned MAX_PLAYERS         = 4;

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  // Conflicting or absent requests both mean "stay put".
  function automatic dir_t resolve_dir(input logic up, input logic down);
    dir_t dir;
    dir = DIR_NONE;
    if (up && !down) begin
      dir = DIR_UP;
    end else if (down && !up) begin
      dir = DIR_DOWN;
    end
    return dir;
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Bundle of per-player paddle inputs and frame-stable direction outputs.
interface paddle_input_ctrl_if #(
  parameter int unsigned N_PLAYERS = 2
);
  logic                 timing_tick;
  logic [N_PLAYERS-1:0] btn_up;
  logic [N_PLAYERS-1:0] btn_down;
  logic [N_PLAYERS-1:0] kbd_up;
  logic [N_PLAYERS-1:0] kbd_down;
  logic [N_PLAYERS-1:0] src_sel;
  logic [N_PLAYERS-1:0] up;
  logic [N_PLAYERS-1:0] down;
  logic                 dir_changed;

  modport master (
    output timing_tick, btn_up, btn_down, kbd_up, kbd_down, src_sel,
    input  up, down, dir_changed
  );

  modport slave (
    input  timing_tick, btn_up, btn_down, kbd_up, kbd_down, src_sel,
    output up, down, dir_changed
  );
endinterface

// File: rtl/paddle_input_ctrl_debounce.sv
// One-bit button conditioner: 2-FF synchroniser followed by a stability counter.
module input_debounce
  import paddle_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/paddle_input_ctrl.sv
// N-player paddle input front end: debounce, source select, resolve, frame register.
// Define PADDLE_INPUT_STICKY_EN to latch sub-frame presses until the next tick.
module paddle_input_ctrl
  import paddle_input_pkg::*;
#(
  parameter int unsigned N_PLAYERS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                i_clk,
  input logic                i_rst_n,
  paddle_input_ctrl_if.slave io_bus
);

  logic [N_PLAYERS-1:0] w_deb_up;
  logic [N_PLAYERS-1:0] w_deb_down;
  logic [N_PLAYERS-1:0] w_res_up;
  logic [N_PLAYERS-1:0] w_res_down;
  logic [N_PLAYERS-1:0] w_nxt_up;
  logic [N_PLAYERS-1:0] w_nxt_down;
  logic [N_PLAYERS-1:0] r_up;
  logic [N_PLAYERS-1:0] r_down;
  logic                 r_dir_changed;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (io_bus.btn_up[g]),
      .o_level (w_deb_up[g])
    );
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (io_bus.btn_down[g]),
      .o_level (w_deb_down[g])
    );
  end

  always_comb begin
    w_res_up   = '0;
    w_res_down = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      dir_t dir;
      dir = resolve_dir(io_bus.src_sel[p] ? io_bus.kbd_up[p]   : w_deb_up[p],
                        io_bus.src_sel[p] ? io_bus.kbd_down[p] : w_deb_down[p]);
      w_res_up[p]   = (dir == DIR_UP);
      w_res_down[p] = (dir == DIR_DOWN);
    end
  end

`ifdef PADDLE_INPUT_STICKY_EN
  logic [N_PLAYERS-1:0] r_seen_up;
  logic [N_PLAYERS-1:0] r_seen_down;
  logic [N_PLAYERS-1:0] r_last_up;
  logic [N_PLAYERS-1:0] w_seen_up;
  logic [N_PLAYERS-1:0] w_seen_down;
  logic [N_PLAYERS-1:0] w_last_up;

  // r_last_up remembers which direction came last, to break ties when both were seen.
  always_comb begin
    w_seen_up   = r_seen_up | w_res_up;
    w_seen_down = r_seen_down | w_res_down;
    w_last_up   = (r_last_up | w_res_up) & ~w_res_down;
    w_nxt_up    = '0;
    w_nxt_down  = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (w_seen_up[p] && w_seen_down[p]) begin
        w_nxt_up[p]   = w_last_up[p];
        w_nxt_down[p] = ~w_last_up[p];
      end else begin
        w_nxt_up[p]   = w_seen_up[p];
        w_nxt_down[p] = w_seen_down[p];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seen_up   <= '0;
      r_seen_down <= '0;
      r_last_up   <= '0;
    end else begin
      r_last_up <= w_last_up;
      if (io_bus.timing_tick) begin
        r_seen_up   <= '0;
        r_seen_down <= '0;
      end else begin
        r_seen_up   <= w_seen_up;
        r_seen_down <= w_seen_down;
      end
    end
  end
`else
  always_comb begin
    w_nxt_up   = w_res_up;
    w_nxt_down = w_res_down;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_up          <= '0;
      r_down        <= '0;
      r_dir_changed <= 1'b0;
    end else begin
      r_dir_changed <= 1'b0;
      if (io_bus.timing_tick) begin
        r_up          <= w_nxt_up;
        r_down        <= w_nxt_down;
        r_dir_changed <= ({w_nxt_up, w_nxt_down} != {r_up, r_down});
      end
    end
  end

  assign io_bus.up          = r_up;
  assign io_bus.down        = r_down;
  assign io_bus.dir_changed = r_dir_changed;

endmodule
